// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM breathing controller: state encodings and
// fixed PWM core configuration.
package pwm_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD_HIGH = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_HOLD_LOW  = 3'd4
  } state_t;

  localparam logic [7:0] PWM_TOP       = 8'hFF;
  localparam int         CLOCK_FREQ_HZ = 25_000_000;
endpackage

// File: rtl/pwm_step_timer.sv
// Fade-step prescaler: counts 0..STEP_CYCLES-1 while running and flags the
// last count as a tick; held at zero whenever not running.
module pwm_step_timer #(
  parameter int STEP_CYCLES = 97_656
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_tick
);
  localparam int             W    = $clog2(STEP_CYCLES);
  localparam logic [W-1:0]   LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                        count <= '0;
    else if (!i_run || count == LAST) count <= '0;
    else                              count <= count + 1'b1;
  end

  assign o_tick = i_run && (count == LAST);
endmodule

// File: rtl/pwm_breathe_controller.sv
// Start/stop-controlled breathing sequencer: ramps the PWM compare value up,
// holds, ramps down, holds, and strobes every update to the PWM core.
module pwm_breathe_controller
  import pwm_pkg::*;
#(
  parameter int STEP_CYCLES = 97_656,
  parameter int HOLD_STEPS  = 64,
  parameter int MAX_COMPARE = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_loop,
  output logic [7:0] o_top,
  output logic       o_top_valid,
  output logic [8:0] o_compare,
  output logic       o_compare_valid,
  output logic       o_busy,
  output logic [2:0] o_state
);
  if (STEP_CYCLES < 2) begin : g_bad_step
    $error("STEP_CYCLES must be >= 2");
  end
  if (HOLD_STEPS < 1) begin : g_bad_hold
    $error("HOLD_STEPS must be >= 1");
  end
  if (MAX_COMPARE < 1 || MAX_COMPARE > 511) begin : g_bad_max
    $error("MAX_COMPARE must be in 1..511");
  end

  localparam int              HW        = $clog2(HOLD_STEPS + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [8:0]      CMP_MAX   = 9'(MAX_COMPARE);

  state_t        state, state_nx;
  logic [8:0]    cmp, cmp_nx;
  logic [HW-1:0] hold, hold_nx;
  logic          vld, vld_nx;
  logic          busy;
  logic          tick;

  pwm_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_run  (state != S_IDLE),
    .o_tick (tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      cmp   <= '0;
      hold  <= '0;
      vld   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cmp   <= cmp_nx;
      hold  <= hold_nx;
      vld   <= vld_nx;
      busy  <= (state_nx != S_IDLE);
    end
  end

  // Stop beats tick; start is only honoured from IDLE and never alongside stop.
  always_comb begin
    state_nx = state;
    cmp_nx   = cmp;
    hold_nx  = hold;
    vld_nx   = 1'b0;
    if (state != S_IDLE && i_stop) begin
      state_nx = S_IDLE;
      cmp_nx   = '0;
      hold_nx  = '0;
      vld_nx   = 1'b1;
    end else if (state == S_IDLE) begin
      if (i_start && !i_stop) begin
        state_nx = S_RAMP_UP;
        cmp_nx   = '0;
        hold_nx  = '0;
        vld_nx   = 1'b1;
      end
    end else if (tick) begin
      vld_nx = 1'b1;
      case (state)
        S_RAMP_UP: begin
          cmp_nx = cmp + 9'd1;
          if (cmp_nx == CMP_MAX) state_nx = S_HOLD_HIGH;
        end
        S_RAMP_DOWN: begin
          cmp_nx = cmp - 9'd1;
          if (cmp_nx == 9'd0) state_nx = S_HOLD_LOW;
        end
        S_HOLD_HIGH, S_HOLD_LOW: begin
          if (hold == HOLD_LAST) begin
            hold_nx = '0;
            if (state == S_HOLD_HIGH) state_nx = S_RAMP_DOWN;
            else                      state_nx = i_loop ? S_RAMP_UP : S_IDLE;
          end else begin
            hold_nx = hold + 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_top           = PWM_TOP;
    o_compare       = cmp;
    o_compare_valid = vld;
    o_top_valid     = vld;
    o_busy          = busy;
    o_state         = state;
  end
endmodule

// File: tb/tb_pwm_breathe_controller.sv
// Scoreboard bench: driver pushes expected strobes (cycle, compare, state)
// from a closed-form breathing model; a monitor pops and compares them.
module tb_pwm_breathe_controller;
  localparam int STEP = 4;
  localparam int HOLD = 2;
  localparam int MAXC = 4;
  localparam int PER  = 2*MAXC + 2*HOLD;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop;
  logic [7:0] top;
  logic       top_valid, cmp_valid, busy;
  logic [8:0] cmp;
  logic [2:0] st;

  pwm_breathe_controller #(
    .STEP_CYCLES(STEP), .HOLD_STEPS(HOLD), .MAX_COMPARE(MAXC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_loop(loop),
    .o_top(top), .o_top_valid(top_valid), .o_compare(cmp),
    .o_compare_valid(cmp_valid), .o_busy(busy), .o_state(st)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int cmp; int st; } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Strobe k of a run: k=0 is the start strobe, then one per tick.
  function automatic int ref_cmp(input int k);
    int t;
    if (k == 0) return 0;
    t = (k - 1) % PER + 1;
    if (t <= MAXC)          return t;
    if (t <= MAXC + HOLD)   return MAXC;
    if (t <= 2*MAXC + HOLD) return 2*MAXC + HOLD - t;
    return 0;
  endfunction

  function automatic int ref_st(input int k, input int periods);
    int t;
    if (k == 0) return 1;
    t = (k - 1) % PER + 1;
    if (t < MAXC)          return 1;
    if (t < MAXC + HOLD)   return 2;
    if (t < 2*MAXC + HOLD) return 3;
    if (t < PER)           return 4;
    return (k / PER < periods) ? 1 : 0;
  endfunction

  task automatic push(input int c, input int v, input int s);
    exp_t e;
    e.cyc = c; e.cmp = v; e.st = s;
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cmp_valid) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_strobe cyc=%0d compare=%0d state=%0d", cyc, cmp, st);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || int'(cmp) != e.cmp || int'(st) != e.st ||
            busy != (e.st != 0) || !top_valid || top != 8'hFF) begin
          miscompares++;
          $display("FAIL strobe cyc=%0d/%0d compare=%0d/%0d state=%0d/%0d busy=%0d top_valid=%0d (got/expected)",
                   cyc, e.cyc, cmp, e.cmp, st, e.st, busy, top_valid);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      vectors++;
      miscompares++;
      e = q.pop_front();
      $display("FAIL missing_strobe cyc=%0d expected at %0d compare=%0d", cyc, e.cyc, e.cmp);
    end
    if (top_valid != cmp_valid || top != 8'hFF) begin
      vectors++;
      miscompares++;
      $display("FAIL top_port cyc=%0d top=%0h top_valid=%0d", cyc, top, top_valid);
    end
  end

  // mode 0: run to completion, 1: stop after strobe ak, 2: async reset after strobe ak
  task automatic run_fade(input int periods, input int mode, input int ak);
    int c0, s, endc, n;
    @(negedge clk);
    c0 = cyc;
    n  = periods * PER;
    s  = c0 + 1 + ak*STEP + int'($urandom_range(0, STEP-1));
    for (int k = 0; k <= n; k++) begin
      if (mode == 0 || c0 + 1 + k*STEP <= s)
        push(c0 + 1 + k*STEP, ref_cmp(k), ref_st(k, periods));
    end
    if (mode == 1) push(s + 1, 0, 0);
    endc = (mode == 0) ? c0 + 1 + n*STEP : (mode == 1) ? s + 1 : s;
    while (cyc < endc) begin
      start = (cyc == c0) || (cyc > c0 && $urandom_range(0, 7) == 0);
      stop  = (mode == 1 && cyc == s);
      if (cyc > c0 && (cyc - c0) % (PER*STEP) == 0)
        loop = ((cyc - c0) / (PER*STEP) < periods);
      else
        loop = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    if (mode == 2) begin
      #2 rst = 1'b1;
      #1;
      check("rst_async_compare", int'(cmp), 0);
      check("rst_async_valid", int'(cmp_valid), 0);
      check("rst_async_busy", int'(busy), 0);
      check("rst_async_state", int'(st), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end else begin
      check("end_busy", int'(busy), 0);
      check("end_state", int'(st), 0);
    end
  endtask

  // Stop alone or start+stop together while IDLE must do nothing.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      stop  = 1'($urandom_range(0, 1));
      start = stop & 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("idle_noise_state", int'(st), 0);
  endtask

  initial begin
    int tmo;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    #1;
    check("rst_top", int'(top), 8'hFF);
    repeat (3) @(negedge clk);
    check("rst_compare", int'(cmp), 0);
    check("rst_valid", int'(cmp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(st), 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_compare", int'(cmp), 0);
    check("idle_state", int'(st), 0);
    check("idle_top", int'(top), 8'hFF);

    run_fade(1, 0, 0);
    run_fade(2, 0, 0);
    run_fade(1, 1, MAXC + HOLD + 1);
    repeat (10) @(negedge clk);
    idle_noise(20);
    repeat (6) begin
      int p, m;
      p = int'($urandom_range(1, 3));
      m = int'($urandom_range(0, 1));
      run_fade(p, m, int'($urandom_range(0, p*PER - 1)));
      idle_noise(int'($urandom_range(3, 12)));
    end
    run_fade(3, 2, int'($urandom_range(1, MAXC + HOLD)));
    idle_noise(15);
    run_fade(1, 0, 0);

    tmo = 0;
    while (q.size() > 0 && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout pending=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwm_breathe_controller.md
# pwm_breathe_controller

- Sequences a downstream PWM core through a repeating "breathing" fade: ramp up, hold high, ramp down, hold low.
- Replaces a free-running compare ramp with a start/stop-controlled state machine.
- Has configurable step rate, hold times and looping.
- Drives the PWM core's top/compare configuration ports with one-cycle valid strobes.

## Interface
- STEP_CYCLES, 97_656: clock cycles per fade step (≥2).
- HOLD_STEPS, 64: steps spent in each hold state (≥1; elaboration error otherwise).
- MAX_COMPARE, 256: peak compare value (1..511); 256 with top 8'hFF = fully on.
- i_clk  in  1  system clock, 25 MHz.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; starts a fade from IDLE.
- i_stop  in  1  one-cycle pulse; aborts to IDLE.
- i_loop  in  1  sampled at end of HOLD_LOW; 1 = repeat, 0 = return to IDLE.
- o_top  out  8  constant 8'hFF.
- o_top_valid  out  1  equals o_compare_valid.
- o_compare  out  9  current duty compare value.
- o_compare_valid  out  1  one-cycle strobe: o_compare holds a new or re-issued value.
- o_busy  out  1  high in every state except IDLE.
- o_state  out  3  IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.

## Operation
- Reset values: state IDLE, o_compare 0, o_compare_valid 0, o_busy 0, prescaler 0, hold counter 0.
- o_top is 8'hFF at all times, including during reset.
- Prescaler runs only when not IDLE.
  - Counts 0..STEP_CYCLES-1.
  - A tick occurs in the cycle where the count equals STEP_CYCLES-1; the count then wraps to 0.
- IDLE
  - On i_start: go to RAMP_UP, clear prescaler and hold counter, o_compare stays 0, strobe valid.
- RAMP_UP
  - On each tick: o_compare += 1, strobe.
  - When the increment yields MAX_COMPARE: go to HOLD_HIGH.
- HOLD_HIGH
  - On each tick: hold counter += 1, strobe (o_compare unchanged).
  - On the tick with hold counter == HOLD_STEPS-1: clear hold counter, go to RAMP_DOWN.
- RAMP_DOWN
  - On each tick: o_compare -= 1, strobe.
  - When the decrement yields 0: go to HOLD_LOW.
- HOLD_LOW
  - Counts ticks as HOLD_HIGH does.
  - On the final tick: go to RAMP_UP if i_loop, else IDLE.
- i_stop in any non-IDLE state: IDLE, o_compare := 0, strobe, counters cleared.
- Priority: i_stop over tick over i_start.
  - i_start while busy is ignored.
  - i_stop while IDLE is ignored (no strobe).
  - i_start and i_stop together in IDLE: nothing happens.
- Arithmetic: o_compare never goes below 0 or above MAX_COMPARE. Prescaler width is $clog2(STEP_CYCLES); hold counter width is $clog2(HOLD_STEPS+1).
- Looping period in ticks: 2·MAX_COMPARE + 2·HOLD_STEPS.

## Timing
- All outputs are registered. o_compare, o_compare_valid, o_busy and o_state update on the same edge.
- i_start accepted at cycle N:
  - N+1: o_busy=1, o_state=1, valid=1 with compare 0.
  - First tick at N+STEP_CYCLES; N+STEP_CYCLES+1: compare=1, valid=1.
- Consecutive strobes while running are exactly STEP_CYCLES apart.
- i_stop at cycle M: M+1 shows IDLE, compare 0, valid=1.
- i_rst asserted mid-fade: outputs reach their reset values immediately, with no strobe.
- After i_rst deasserts, the block waits in IDLE for i_start.
- i_loop is sampled only on the final HOLD_LOW tick.

## Structure
- Shared package/include pwm_pkg:
  - state encodings;
  - PWM_TOP = 8'hFF;
  - CLOCK_FREQ_HZ = 25_000_000.
- One sub-module, pwm_step_timer:
  - parameter STEP_CYCLES;
  - inputs i_clk, i_rst, i_run;
  - output o_tick;
  - the counter clears whenever i_run=0.
- The FSM, compare register and hold counter live in the top module.

## Test plan
Bench parameters are STEP_CYCLES=4, HOLD_STEPS=2, MAX_COMPARE=4 unless noted.
- Reset then idle 50 cycles -> compare 0, valid never high, o_top 8'hFF, o_state 0.
- i_start, i_loop=0:
  - strobes every 4 cycles;
  - compare sequence 0,1,2,3,4,4,4,3,2,1,0,0,0;
  - then IDLE, o_busy=0.
- i_loop=1 -> after HOLD_LOW returns to RAMP_UP; second period is identical; 12 ticks per period.
- i_stop mid-RAMP_DOWN at compare 3 -> next cycle IDLE, compare 0, one strobe; then no further strobes.
- i_start pulsed during HOLD_HIGH; i_start+i_stop together while IDLE -> neither changes state or strobe timing.
- Async i_rst asserted between clock edges mid-fade -> outputs cleared before the next edge. Default params: first compare=1 strobe 97_656 cycles after start.
